// File: rtl/shunt_fringe_if.sv
`default_nettype none
// ============================================================================
// Module      : shunt_fringe_if
// Description : Co-simulation link endpoint. Registers with a peer, exports
//               local payloads over a valid/ready link, and keeps a small
//               signal database of payloads received from the peer.
// Revision    : 1.0 - initial release
// ============================================================================
module shunt_fringe_if #(
    parameter int NUM_SIG = 4,
    parameter int DW      = 9,
    parameter int SIMID_W = 8,
    localparam int IW     = (NUM_SIG > 1) ? $clog2(NUM_SIG) : 1
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    // registration
    input  logic               reg_req_i,
    input  logic [SIMID_W-1:0] reg_simid_i,
    output logic               registered_o,
    // local put
    input  logic               put_req_i,
    input  logic [IW-1:0]      put_idx_i,
    input  logic [DW-1:0]      put_data_i,
    output logic               put_ack_o,
    // link transmit
    output logic               tx_valid_o,
    input  logic               tx_ready_i,
    output logic [1:0]         tx_type_o,
    output logic [IW-1:0]      tx_idx_o,
    output logic [DW-1:0]      tx_data_o,
    // link receive
    input  logic               rx_valid_i,
    input  logic [1:0]         rx_type_i,
    input  logic [IW-1:0]      rx_idx_i,
    input  logic [DW-1:0]      rx_data_i,
    // signal database
    output logic [NUM_SIG-1:0] data_valid_o,
    input  logic [IW-1:0]      rd_idx_i,
    output logic [DW-1:0]      rd_data_o,
    input  logic               clr_i,
    input  logic [IW-1:0]      clr_idx_i,
    output logic [NUM_SIG-1:0] overrun_o,
    output logic [31:0]        time_o
);

    localparam logic [1:0] UNREG    = 2'd0;
    localparam logic [1:0] REG_SEND = 2'd1;
    localparam logic [1:0] REG_WAIT = 2'd2;
    localparam logic [1:0] READY    = 2'd3;

    localparam logic [1:0] TYPE_DATA = 2'd0;
    localparam logic [1:0] TYPE_REG  = 2'd1;
    localparam logic [1:0] TYPE_ACK  = 2'd2;

    logic [1:0]         state_q, state_d;
    logic               txv_q, txv_d;
    logic [1:0]         txt_q, txt_d;
    logic [IW-1:0]      txi_q, txi_d;
    logic [DW-1:0]      txd_q, txd_d;
    logic [DW-1:0]      db_q [NUM_SIG];
    logic [DW-1:0]      db_d [NUM_SIG];
    logic [NUM_SIG-1:0] valid_q, valid_d;
    logic [NUM_SIG-1:0] ovr_q, ovr_d;
    logic [31:0]        time_q;

    logic [DW-1:0]      simid_ext;
    logic               rx_in_range;
    logic               clr_in_range;
    logic               rx_wr;
    logic               put_accept;

    // Fit the simulation ID into the payload field (zero-extend or truncate).
    if (SIMID_W == DW) begin : g_simid_eq
        assign simid_ext = reg_simid_i;
    end else if (SIMID_W < DW) begin : g_simid_pad
        assign simid_ext = {{(DW-SIMID_W){1'b0}}, reg_simid_i};
    end else begin : g_simid_trunc
        assign simid_ext = reg_simid_i[DW-1:0];
    end

    // Indices only need range checks when NUM_SIG is not a power of two.
    if (NUM_SIG == (1 << IW)) begin : g_idx_full
        assign rx_in_range  = 1'b1;
        assign clr_in_range = 1'b1;
    end else begin : g_idx_part
        assign rx_in_range  = ({1'b0, rx_idx_i}  < (IW+1)'(NUM_SIG));
        assign clr_in_range = ({1'b0, clr_idx_i} < (IW+1)'(NUM_SIG));
    end

    assign put_accept = (state_q == READY) && put_req_i && (!txv_q || tx_ready_i);
    assign rx_wr      = rx_valid_i && (rx_type_i == TYPE_DATA) && rx_in_range;

    // Registration FSM and transmit holding register.
    always_comb begin
        state_d = state_q;
        txv_d   = txv_q;
        txt_d   = txt_q;
        txi_d   = txi_q;
        txd_d   = txd_q;
        case (state_q)
            UNREG: begin
                if (reg_req_i) begin
                    txv_d   = 1'b1;
                    txt_d   = TYPE_REG;
                    txi_d   = '0;
                    txd_d   = simid_ext;
                    state_d = REG_SEND;
                end
            end
            REG_SEND: begin
                if (txv_q && tx_ready_i) begin
                    txv_d   = 1'b0;
                    state_d = REG_WAIT;
                end
            end
            REG_WAIT: begin
                if (rx_valid_i && (rx_type_i == TYPE_ACK)) begin
                    state_d = READY;
                end
            end
            READY: begin
                if (put_accept) begin
                    txv_d = 1'b1;
                    txt_d = TYPE_DATA;
                    txi_d = put_idx_i;
                    txd_d = put_data_i;
                end else if (txv_q && tx_ready_i) begin
                    txv_d = 1'b0;
                end
            end
            default: state_d = UNREG;
        endcase
    end

    // Signal database update; a receive overrides a clear of the same entry.
    always_comb begin
        db_d    = db_q;
        valid_d = valid_q;
        ovr_d   = ovr_q;
        if (clr_i && clr_in_range) begin
            valid_d[clr_idx_i] = 1'b0;
        end
        if (rx_wr) begin
            if (valid_q[rx_idx_i]) begin
                ovr_d[rx_idx_i] = 1'b1;
            end
            valid_d[rx_idx_i] = 1'b1;
            db_d[rx_idx_i]    = rx_data_i;
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= UNREG;
            txv_q   <= 1'b0;
            txt_q   <= '0;
            txi_q   <= '0;
            txd_q   <= '0;
            valid_q <= '0;
            ovr_q   <= '0;
            time_q  <= '0;
            for (int i = 0; i < NUM_SIG; i++) begin
                db_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            txv_q   <= txv_d;
            txt_q   <= txt_d;
            txi_q   <= txi_d;
            txd_q   <= txd_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
            time_q  <= time_q + 32'd1;
            db_q    <= db_d;
        end
    end

    assign registered_o = (state_q == READY);
    assign put_ack_o    = put_accept;
    assign tx_valid_o   = txv_q;
    assign tx_type_o    = txt_q;
    assign tx_idx_o     = txi_q;
    assign tx_data_o    = txd_q;
    assign data_valid_o = valid_q;
    assign overrun_o    = ovr_q;
    assign rd_data_o    = db_q[rd_idx_i];
    assign time_o       = time_q;

endmodule
`default_nettype wire

// File: tb/tb_shunt_fringe_if.sv
`default_nettype none
// ============================================================================
// Module      : tb_shunt_fringe_if
// Description : Self-checking bench for shunt_fringe_if.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_shunt_fringe_if;

    localparam int NUM_SIG = 4;
    localparam int DW      = 9;
    localparam int SIMID_W = 8;
    localparam int IW      = 2;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               reg_req;
    logic [SIMID_W-1:0] reg_simid;
    logic               registered;
    logic               put_req;
    logic [IW-1:0]      put_idx;
    logic [DW-1:0]      put_data;
    logic               put_ack;
    logic               tx_valid;
    logic               tx_ready;
    logic [1:0]         tx_type;
    logic [IW-1:0]      tx_idx;
    logic [DW-1:0]      tx_data;
    logic               rx_valid;
    logic [1:0]         rx_type;
    logic [IW-1:0]      rx_idx;
    logic [DW-1:0]      rx_data;
    logic [NUM_SIG-1:0] data_valid;
    logic [IW-1:0]      rd_idx;
    logic [DW-1:0]      rd_data;
    logic               clr;
    logic [IW-1:0]      clr_idx;
    logic [NUM_SIG-1:0] overrun;
    logic [31:0]        time_v;

    int checks = 0;
    int errors = 0;
    int dut_beats = 0;

    always #5 clk = ~clk;

    shunt_fringe_if #(.NUM_SIG(NUM_SIG), .DW(DW), .SIMID_W(SIMID_W)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .reg_req_i(reg_req), .reg_simid_i(reg_simid), .registered_o(registered),
        .put_req_i(put_req), .put_idx_i(put_idx), .put_data_i(put_data), .put_ack_o(put_ack),
        .tx_valid_o(tx_valid), .tx_ready_i(tx_ready), .tx_type_o(tx_type),
        .tx_idx_o(tx_idx), .tx_data_o(tx_data),
        .rx_valid_i(rx_valid), .rx_type_i(rx_type), .rx_idx_i(rx_idx), .rx_data_i(rx_data),
        .data_valid_o(data_valid), .rd_idx_i(rd_idx), .rd_data_o(rd_data),
        .clr_i(clr), .clr_idx_i(clr_idx), .overrun_o(overrun), .time_o(time_v)
    );

    // ---------------- reference model ----------------
    // Phase of the registration handshake as seen from the link.
    localparam int PH_IDLE = 0, PH_SENDING = 1, PH_AWAIT = 2, PH_LIVE = 3;
    int               m_phase;
    logic             m_txv;
    logic [1:0]       m_txt;
    logic [IW-1:0]    m_txi;
    logic [DW-1:0]    m_txd;
    logic [DW-1:0]    m_pay [NUM_SIG];
    logic [NUM_SIG-1:0] m_vld, m_ovr;
    logic [31:0]      m_time;

    typedef struct {
        logic         rxv;
        logic [1:0]   rxt;
        logic [IW-1:0] rxi;
        logic [DW-1:0] rxd;
        logic         clr;
        logic [IW-1:0] ci;
        logic [IW-1:0] rdi;
        logic [NUM_SIG-1:0] ev;
        logic [NUM_SIG-1:0] eo;
        logic [DW-1:0] erd;
    } vec_t;
    vec_t tbl [10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = PH_IDLE;
        m_txv = 1'b0; m_txt = '0; m_txi = '0; m_txd = '0;
        m_vld = '0; m_ovr = '0; m_time = '0;
        for (int i = 0; i < NUM_SIG; i++) m_pay[i] = '0;
    endtask

    task automatic check_state();
        chk("registered", registered, m_phase == PH_LIVE);
        chk("tx_valid", tx_valid, m_txv);
        chk("tx_type", tx_type, m_txt);
        chk("tx_idx", tx_idx, m_txi);
        chk("tx_data", tx_data, m_txd);
        chk("data_valid", data_valid, m_vld);
        chk("overrun", overrun, m_ovr);
        chk("time", time_v, m_time);
        chk("rd_data", rd_data, m_pay[rd_idx]);
    endtask

    // One clock: check combinational outputs, advance the model, then check state.
    task automatic cycle();
        logic acc, hs;
        logic [NUM_SIG-1:0] old_v;
        #1;
        acc = (m_phase == PH_LIVE) && put_req && (!m_txv || tx_ready);
        hs  = m_txv && tx_ready;
        chk("put_ack", put_ack, acc);
        chk("rd_data_comb", rd_data, m_pay[rd_idx]);
        if (tx_valid && tx_ready) dut_beats++;
        case (m_phase)
            PH_IDLE: if (reg_req) begin
                m_txv = 1'b1; m_txt = 2'd1; m_txi = '0; m_txd = {1'b0, reg_simid};
                m_phase = PH_SENDING;
            end
            PH_SENDING: if (hs) begin m_txv = 1'b0; m_phase = PH_AWAIT; end
            PH_AWAIT: if (rx_valid && rx_type == 2'd2) m_phase = PH_LIVE;
            default: begin
                if (acc) begin
                    m_txv = 1'b1; m_txt = 2'd0; m_txi = put_idx; m_txd = put_data;
                end else if (hs) m_txv = 1'b0;
            end
        endcase
        old_v = m_vld;
        if (clr) m_vld[clr_idx] = 1'b0;
        if (rx_valid && rx_type == 2'd0 && int'(rx_idx) < NUM_SIG) begin
            if (old_v[rx_idx]) m_ovr[rx_idx] = 1'b1;
            m_pay[rx_idx] = rx_data;
            m_vld[rx_idx] = 1'b1;
        end
        m_time = m_time + 32'd1;
        @(posedge clk);
        #1;
        check_state();
    endtask

    task automatic idle_inputs();
        reg_req = 0; reg_simid = '0; put_req = 0; put_idx = '0; put_data = '0;
        tx_ready = 0; rx_valid = 0; rx_type = '0; rx_idx = '0; rx_data = '0;
        rd_idx = '0; clr = 0; clr_idx = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        #2;
        model_reset();
        check_state();
        chk("reset_put_ack", put_ack, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic register_peer(input logic [SIMID_W-1:0] id);
        reg_req = 1; reg_simid = id; tx_ready = 1;
        cycle();
        reg_req = 0;
        cycle();
        rx_valid = 1; rx_type = 2'd2;
        cycle();
        rx_valid = 0; rx_type = 2'd0; tx_ready = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int beats0;
        tbl[0] = '{1'b1, 2'd0, 2'd3, 9'h1FF, 1'b0, 2'd0, 2'd3, 4'b1000, 4'b0000, 9'h1FF};
        tbl[1] = '{1'b0, 2'd0, 2'd0, 9'h000, 1'b1, 2'd3, 2'd3, 4'b0000, 4'b0000, 9'h1FF};
        tbl[2] = '{1'b1, 2'd0, 2'd1, 9'h011, 1'b0, 2'd0, 2'd1, 4'b0010, 4'b0000, 9'h011};
        tbl[3] = '{1'b1, 2'd0, 2'd1, 9'h022, 1'b0, 2'd0, 2'd1, 4'b0010, 4'b0010, 9'h022};
        tbl[4] = '{1'b1, 2'd0, 2'd1, 9'h033, 1'b1, 2'd1, 2'd1, 4'b0010, 4'b0010, 9'h033};
        tbl[5] = '{1'b1, 2'd0, 2'd2, 9'h044, 1'b1, 2'd1, 2'd2, 4'b0100, 4'b0010, 9'h044};
        tbl[6] = '{1'b1, 2'd1, 2'd0, 9'h0AA, 1'b0, 2'd0, 2'd0, 4'b0100, 4'b0010, 9'h000};
        tbl[7] = '{1'b1, 2'd3, 2'd0, 9'h0BB, 1'b0, 2'd0, 2'd0, 4'b0100, 4'b0010, 9'h000};
        tbl[8] = '{1'b1, 2'd2, 2'd0, 9'h0CC, 1'b0, 2'd0, 2'd0, 4'b0100, 4'b0010, 9'h000};
        tbl[9] = '{1'b0, 2'd0, 2'd0, 9'h000, 1'b1, 2'd2, 2'd2, 4'b0000, 4'b0010, 9'h044};

        do_reset();

        // Free-running counter from reset release.
        for (int i = 0; i < 3; i++) cycle();
        chk("time_after3", time_v, 32'd3);

        // Receive/consume/overrun/collision vectors (unregistered: rx still works).
        for (int i = 0; i < 10; i++) begin
            rx_valid = tbl[i].rxv; rx_type = tbl[i].rxt; rx_idx = tbl[i].rxi;
            rx_data = tbl[i].rxd; clr = tbl[i].clr; clr_idx = tbl[i].ci; rd_idx = tbl[i].rdi;
            cycle();
            chk($sformatf("tbl%0d_valid", i), data_valid, tbl[i].ev);
            chk($sformatf("tbl%0d_ovr", i), overrun, tbl[i].eo);
            chk($sformatf("tbl%0d_rd", i), rd_data, tbl[i].erd);
        end
        chk("tbl_not_registered", registered, 1'b0);
        idle_inputs();

        // Put while unregistered is dropped.
        put_req = 1; put_idx = 2'd0; put_data = 9'h1AB;
        for (int i = 0; i < 2; i++) begin
            cycle();
            chk("unreg_txv", tx_valid, 1'b0);
        end
        put_req = 0;

        // Registration beat and ack.
        beats0 = dut_beats;
        reg_req = 1; reg_simid = 8'h05; tx_ready = 0;
        cycle();
        chk("reg_tx_valid", tx_valid, 1'b1);
        chk("reg_tx_type", tx_type, 2'd1);
        chk("reg_tx_data", tx_data, 9'h005);
        reg_req = 0; tx_ready = 1;
        cycle();
        chk("reg_tx_done", tx_valid, 1'b0);
        chk("reg_beats", dut_beats - beats0, 1);
        reg_req = 1; reg_simid = 8'h77;
        cycle();
        chk("reg_req_ignored", tx_valid, 1'b0);
        reg_req = 0;
        rx_valid = 1; rx_type = 2'd2;
        cycle();
        chk("registered", registered, 1'b1);
        rx_valid = 0; rx_type = 2'd0;

        // Put under back-pressure.
        tx_ready = 0; put_req = 1; put_idx = 2'd0; put_data = 9'h101;
        cycle();
        put_req = 0;
        beats0 = dut_beats;
        for (int i = 0; i < 3; i++) begin
            if (i == 1) begin put_req = 1; put_data = 9'h0EE; end
            else put_req = 0;
            cycle();
            chk("bp_data_held", tx_data, 9'h101);
            chk("bp_valid_held", tx_valid, 1'b1);
        end
        put_req = 0; tx_ready = 1;
        cycle();
        chk("bp_single_beat", dut_beats - beats0, 1);
        chk("bp_done", tx_valid, 1'b0);

        // Back-to-back puts at full rate.
        for (int i = 0; i < 4; i++) begin
            put_req = 1; put_idx = 2'(i); put_data = 9'(9'h050 + i);
            cycle();
        end
        put_req = 0;
        cycle();

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            reg_req  = 1'($urandom_range(0, 1));
            put_req  = ($urandom_range(0, 2) != 0);
            put_idx  = 2'($urandom);
            put_data = 9'($urandom);
            tx_ready = ($urandom_range(0, 3) != 0);
            rx_valid = 1'($urandom_range(0, 1));
            rx_type  = 2'($urandom);
            rx_idx   = 2'($urandom);
            rx_data  = 9'($urandom);
            rd_idx   = 2'($urandom);
            clr      = 1'($urandom_range(0, 1));
            clr_idx  = 2'($urandom);
            cycle();
        end
        idle_inputs();

        // Reset while waiting for the ack abandons registration.
        do_reset();
        reg_req = 1; reg_simid = 8'h33; tx_ready = 1;
        cycle();
        reg_req = 0;
        cycle();
        do_reset();
        rx_valid = 1; rx_type = 2'd2;
        cycle();
        chk("abandoned_reg", registered, 1'b0);
        rx_valid = 0;
        register_peer(8'h09);
        chk("reregistered", registered, 1'b1);

        // Counter wrap.
        force dut.time_q = 32'hFFFF_FFFE;
        #1;
        release dut.time_q;
        m_time = 32'hFFFF_FFFE;
        cycle();
        chk("time_max", time_v, 32'hFFFF_FFFF);
        cycle();
        chk("time_wrap", time_v, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
